// File: rtl/pcie_tx_pkg.sv
// Shared definitions for the PCIe transmit path: default sizing, channel index type,
// and the bit ordering of per-channel status flags consumed by the arbiter.
package pcie_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 6;
    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_NUM_VC     = 2;

    typedef logic [7:0] vc_idx_t;

    localparam int FLAG_FULL  = 0;
    localparam int FLAG_EMPTY = 1;
    localparam int FLAG_AF    = 2;
    localparam int FLAG_AE    = 3;
    localparam int FLAG_ERR   = 4;
    localparam int FLAG_NUM   = 5;

    typedef logic [FLAG_NUM-1:0] flags_t;

    function automatic int depth_of(input int addrWidth);
        return 1 << addrWidth;
    endfunction

endpackage

// File: rtl/vc_fifo_channel.sv
// One virtual-channel FIFO: memory, wrapping pointers, saturating-free occupancy counter,
// combinational status flags and a sticky overflow/underflow error.
module vc_fifo_channel
    import pcie_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  init_i,
    input  logic                  wrEnable_i,
    input  logic                  rdEnable_i,
    input  logic [DATA_WIDTH-1:0] dataIn_i,
    input  logic [ADDR_WIDTH:0]   umbralAf_i,
    input  logic [ADDR_WIDTH:0]   umbralAe_i,
    output logic [DATA_WIDTH-1:0] dataOut_o,
    output logic                  validOut_o,
    output logic [DATA_WIDTH-1:0] headData_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almostFull_o,
    output logic                  almostEmpty_o,
    output logic                  error_o
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
    logic                  validOut_q, validOut_d;
    logic                  error_q, error_d;
    logic [ADDR_WIDTH:0]   afThr, afLevel;
    logic                  clear, push, pop, overflow, underflow;
    flags_t                flags;

    // Thresholds above DEPTH saturate so the almost-full level never underflows.
    always_comb begin
        flags            = '0;
        flags[FLAG_FULL] = (count_q == DEPTH_CNT);
        flags[FLAG_EMPTY]= (count_q == '0);
        afThr            = (umbralAf_i > DEPTH_CNT) ? DEPTH_CNT : umbralAf_i;
        afLevel          = DEPTH_CNT - afThr;
        flags[FLAG_AF]   = (count_q >= afLevel) & ~flags[FLAG_FULL];
        flags[FLAG_AE]   = (count_q <= umbralAe_i) & ~flags[FLAG_EMPTY];
        flags[FLAG_ERR]  = error_q;
    end

    assign clear     = reset_i | ~init_i;
    assign push      = wrEnable_i & (~flags[FLAG_FULL] | rdEnable_i);
    assign pop       = rdEnable_i & ~flags[FLAG_EMPTY];
    assign overflow  = wrEnable_i & flags[FLAG_FULL] & ~rdEnable_i;
    assign underflow = rdEnable_i & flags[FLAG_EMPTY];

    always_comb begin
        wrPtr_d    = push ? wrPtr_q + ADDR_WIDTH'(1) : wrPtr_q;
        rdPtr_d    = pop  ? rdPtr_q + ADDR_WIDTH'(1) : rdPtr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
        dataOut_d  = pop ? mem_q[rdPtr_q] : '0;
        validOut_d = pop;
        error_d    = error_q | overflow | underflow;
    end

    always_ff @(posedge clk_i) begin
        if (clear) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            dataOut_q  <= '0;
            validOut_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            dataOut_q  <= dataOut_d;
            validOut_q <= validOut_d;
            error_q    <= error_d;
        end
    end

    // Storage is deliberately left uncleared; an empty channel masks it on the head port.
    always_ff @(posedge clk_i) begin
        if (push && !clear) begin
            mem_q[wrPtr_q] <= dataIn_i;
        end
    end

    assign dataOut_o     = dataOut_q;
    assign validOut_o    = validOut_q;
    assign headData_o    = flags[FLAG_EMPTY] ? '0 : mem_q[rdPtr_q];
    assign count_o       = count_q;
    assign full_o        = flags[FLAG_FULL];
    assign empty_o       = flags[FLAG_EMPTY];
    assign almostFull_o  = flags[FLAG_AF];
    assign almostEmpty_o = flags[FLAG_AE];
    assign error_o       = flags[FLAG_ERR];

endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent virtual-channel FIFOs ahead of the transmit arbiter;
// channel k occupies slice k of every flattened bus.
module vc_fifo_bank
    import pcie_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_VC     = DEFAULT_NUM_VC
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             init,
    input  logic [NUM_VC-1:0]                wr_enable,
    input  logic [NUM_VC-1:0]                rd_enable,
    input  logic [NUM_VC*DATA_WIDTH-1:0]     data_in,
    input  logic [NUM_VC*(ADDR_WIDTH+1)-1:0] umbral_af,
    input  logic [NUM_VC*(ADDR_WIDTH+1)-1:0] umbral_ae,
    output logic [NUM_VC*DATA_WIDTH-1:0]     data_out,
    output logic [NUM_VC-1:0]                valid_out,
    output logic [NUM_VC*DATA_WIDTH-1:0]     head_data,
    output logic [NUM_VC*(ADDR_WIDTH+1)-1:0] count,
    output logic [NUM_VC-1:0]                full,
    output logic [NUM_VC-1:0]                empty,
    output logic [NUM_VC-1:0]                almost_full,
    output logic [NUM_VC-1:0]                almost_empty,
    output logic [NUM_VC-1:0]                error
);

    localparam int CW = ADDR_WIDTH + 1;

    for (genvar k = 0; k < NUM_VC; k++) begin : g_vc
        vc_fifo_channel #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_channel (
            .clk_i        (clk),
            .reset_i      (reset),
            .init_i       (init),
            .wrEnable_i   (wr_enable[k]),
            .rdEnable_i   (rd_enable[k]),
            .dataIn_i     (data_in[k*DATA_WIDTH +: DATA_WIDTH]),
            .umbralAf_i   (umbral_af[k*CW +: CW]),
            .umbralAe_i   (umbral_ae[k*CW +: CW]),
            .dataOut_o    (data_out[k*DATA_WIDTH +: DATA_WIDTH]),
            .validOut_o   (valid_out[k]),
            .headData_o   (head_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .count_o      (count[k*CW +: CW]),
            .full_o       (full[k]),
            .empty_o      (empty[k]),
            .almostFull_o (almost_full[k]),
            .almostEmpty_o(almost_empty[k]),
            .error_o      (error[k])
        );
    end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Directed self-checking bench for vc_fifo_bank with DATA_WIDTH=6, ADDR_WIDTH=4, NUM_VC=2.
module tb_vc_fifo_bank;

    logic        clk = 1'b0;
    logic        reset, init;
    logic [1:0]  wrEn, rdEn;
    logic [11:0] dataIn;
    logic [9:0]  umbralAf, umbralAe;
    logic [11:0] dataOut, headData;
    logic [1:0]  validOut, full, empty, almostFull, almostEmpty, error;
    logic [9:0]  count;

    int total = 0;
    int bad   = 0;
    logic [5:0] model [$];
    logic [5:0] expWord;

    always #5 clk = ~clk;

    vc_fifo_bank #(.DATA_WIDTH(6), .ADDR_WIDTH(4), .NUM_VC(2)) dut (
        .clk(clk), .reset(reset), .init(init),
        .wr_enable(wrEn), .rd_enable(rdEn), .data_in(dataIn),
        .umbral_af(umbralAf), .umbral_ae(umbralAe),
        .data_out(dataOut), .valid_out(validOut), .head_data(headData),
        .count(count), .full(full), .empty(empty),
        .almost_full(almostFull), .almost_empty(almostEmpty), .error(error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int vc, input logic wr, input logic rd, input logic [5:0] d);
        wrEn[vc]          = wr;
        rdEn[vc]          = rd;
        dataIn[vc*6 +: 6] = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1; init = 1'b1;
        wrEn = '0; rdEn = '0; dataIn = '0;
        umbralAf = '0; umbralAe = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checkOutput("rst_count", count, 0);
        checkOutput("rst_empty", empty, 2'b11);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_valid", validOut, 0);
        checkOutput("rst_ae", almostEmpty, 0);
        checkOutput("rst_head", headData, 0);

        // Fill VC0 with 0x01..0x10, then drain it in order.
        $display("[TB] test 1: fill and drain VC0");
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 6'(i));
            tick();
            checkOutput("t1_count", count[4:0], i);
        end
        checkOutput("t1_full", full[0], 1);
        checkOutput("t1_head", headData[5:0], 6'h01);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 1'b0, 1'b1, 6'h00);
            tick();
            checkOutput("t1_valid", validOut[0], 1);
            checkOutput("t1_data", dataOut[5:0], 6'(i));
        end
        applyStimulus(0, 1'b0, 1'b0, 6'h00);
        tick();
        checkOutput("t1_idle_valid", validOut[0], 0);
        checkOutput("t1_idle_data", dataOut[5:0], 0);
        checkOutput("t1_empty", empty[0], 1);

        // Overflow on a full channel, then push+pop at full.
        $display("[TB] test 2: overflow");
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 6'(i + 16));
            tick();
        end
        checkOutput("t2_full", full[0], 1);
        applyStimulus(0, 1'b1, 1'b0, 6'h2A);
        tick();
        checkOutput("t2_ovf_count", count[4:0], 16);
        checkOutput("t2_ovf_error", error[0], 1);
        applyStimulus(0, 1'b0, 1'b0, 6'h00);
        tick();
        checkOutput("t2_sticky", error[0], 1);
        applyStimulus(0, 1'b1, 1'b1, 6'h2B);
        tick();
        checkOutput("t2_both_valid", validOut[0], 1);
        checkOutput("t2_both_data", dataOut[5:0], 6'h11);
        checkOutput("t2_both_count", count[4:0], 16);
        checkOutput("t2_both_error", error[0], 1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1'b0, 1'b1, 6'h00);
            tick();
            expWord = (i < 15) ? 6'(i + 18) : 6'h2B;
            checkOutput("t2_drain", dataOut[5:0], expWord);
        end
        applyStimulus(0, 1'b0, 1'b0, 6'h00);
        tick();
        checkOutput("t2_drained", count[4:0], 0);

        // Underflow on VC1, then push+pop on an empty channel.
        $display("[TB] test 3: underflow");
        applyStimulus(1, 1'b0, 1'b1, 6'h00);
        tick();
        checkOutput("t3_valid", validOut[1], 0);
        checkOutput("t3_error", error[1], 1);
        applyStimulus(1, 1'b1, 1'b1, 6'h05);
        tick();
        checkOutput("t3_count", count[9:5], 1);
        checkOutput("t3_head", headData[11:6], 6'h05);
        checkOutput("t3_nofall", validOut[1], 0);
        applyStimulus(1, 1'b0, 1'b0, 6'h00);

        // Almost-full/almost-empty windows with af=3, ae=2.
        $display("[TB] test 4: thresholds");
        umbralAf[4:0] = 5'd3;
        umbralAe[4:0] = 5'd2;
        #1;
        checkOutput("t4_af0", almostFull[0], 0);
        checkOutput("t4_ae0", almostEmpty[0], 0);
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(0, 1'b1, 1'b0, 6'(i));
            tick();
            checkOutput("t4_af", almostFull[0], (i >= 13 && i <= 15));
            checkOutput("t4_ae", almostEmpty[0], (i >= 1 && i <= 2));
            if (i == 11) begin
                umbralAf[4:0] = 5'd5;
                #1;
                checkOutput("t4_af_live", almostFull[0], 1);
                umbralAf[4:0] = 5'd3;
                #1;
                checkOutput("t4_af_back", almostFull[0], 0);
            end
        end
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 1'b0, 1'b1, 6'h00);
            tick();
            checkOutput("t4_pop", dataOut[5:0], 6'(i));
        end
        applyStimulus(0, 1'b0, 1'b0, 6'h00);
        tick();
        checkOutput("t4_count8", count[4:0], 8);

        // Interleaved push/pop at count 8 drives both pointers around the ring.
        $display("[TB] test 5: wrap");
        model.delete();
        for (int i = 9; i <= 16; i++) model.push_back(6'(i));
        for (int j = 0; j < 40; j++) begin
            applyStimulus(0, 1'b1, 1'b1, 6'(j + 17));
            model.push_back(6'(j + 17));
            tick();
            expWord = model.pop_front();
            checkOutput("t5_data", dataOut[5:0], expWord);
            checkOutput("t5_count", count[4:0], 8);
            checkOutput("t5_vc1_count", count[9:5], 1);
            checkOutput("t5_vc1_error", error[1], 1);
        end
        applyStimulus(0, 1'b0, 1'b0, 6'h00);
        tick();
        checkOutput("t5_vc1_flags", {full[1], empty[1], almostFull[1], almostEmpty[1]}, 4'b0000);
        checkOutput("t5_head", headData[5:0], model[0]);

        // Clear while a pop is in flight and a push is requested.
        $display("[TB] test 6: clear mid-operation");
        applyStimulus(0, 1'b0, 1'b1, 6'h00);
        tick();
        checkOutput("t6_inflight", validOut[0], 1);
        applyStimulus(0, 1'b1, 1'b1, 6'h3F);
        reset = 1'b1;
        tick();
        checkOutput("t6_valid", validOut, 0);
        checkOutput("t6_data", dataOut, 0);
        checkOutput("t6_count", count, 0);
        checkOutput("t6_error", error, 0);
        checkOutput("t6_empty", empty, 2'b11);
        reset = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 6'h00);
        applyStimulus(1, 1'b1, 1'b0, 6'h07);
        tick(); tick();
        checkOutput("t6_vc1_fill", count[9:5], 2);
        applyStimulus(1, 1'b1, 1'b1, 6'h09);
        init = 1'b0;
        tick();
        checkOutput("t6_init_count", count[9:5], 0);
        checkOutput("t6_init_valid", validOut[1], 0);
        checkOutput("t6_init_empty", empty[1], 1);
        init = 1'b1;
        applyStimulus(1, 1'b0, 1'b0, 6'h00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
